fetch_bus_ctrl: RTL and testbench

//  Memory-bus master feeding pipe_stage0. Owns program counters PCRA0/PCRA1, drives the fetch address,
//  and grants single data accesses to later pipeline stages. Generates BusRequest/FetchSuppress in the

---
 rtl/fetch_bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_fetch_bus_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_bus_ctrl.sv
// Memory-bus master for pipe_stage0. It keeps the two program counters, drives the fetch
// stream, and interleaves single data accesses from later stages as bus bubbles.
module fetch_bus_ctrl #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BranchLoad,
    input  logic [AW-1:0] BranchAddr,
    input  logic          PCFlipReq,
    input  logic          StallIn,
    input  logic          DataReq,
    input  logic          DataWrite,
    input  logic [AW-1:0] DataAddr,
    input  logic [DW-1:0] DataWData,
    input  logic          DataWait,
    input  logic [DW-1:0] MemRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] MemWData,
    output logic          DataAck,
    output logic [DW-1:0] DataRData,
    output logic          BusRequest,
    output logic          FetchSuppress,
    output logic          Flag5_PCRA_Flip,
    output logic [AW-1:0] PC
);
    typedef enum logic {ST_FETCH = 1'b0, ST_DATA = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pcra0_q, pcra0_d;
    logic [AW-1:0] pcra1_q, pcra1_d;
    logic          flip_q, flip_d;
    logic [AW-1:0] last_fetch_addr_q, last_fetch_addr_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          req_write_q, req_write_d;
    logic [DW-1:0] req_wdata_q, req_wdata_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;

    logic [AW-1:0] active_pc;
    logic          fetch_adv;
    logic [AW-1:0] pc_new;

    assign active_pc = flip_q ? pcra1_q : pcra0_q;
    assign fetch_adv = (state_q == ST_FETCH) && !DataReq && !StallIn;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (DataReq)   state_d = ST_DATA;
            ST_DATA:  if (!DataWait) state_d = ST_FETCH;
            default:                 state_d = ST_FETCH;
        endcase
    end

    // Datapath next values; the branch targets the register that is active before any flip
    always_comb begin
        pcra0_d           = pcra0_q;
        pcra1_d           = pcra1_q;
        flip_d            = flip_q ^ PCFlipReq;
        last_fetch_addr_d = last_fetch_addr_q;
        req_addr_d        = req_addr_q;
        req_write_d       = req_write_q;
        req_wdata_d       = req_wdata_q;
        data_rdata_d      = data_rdata_q;
        pc_new            = BranchLoad ? BranchAddr : (active_pc + AW'(1));

        if (BranchLoad || fetch_adv) begin
            if (flip_q) pcra1_d = pc_new;
            else        pcra0_d = pc_new;
        end
        if (fetch_adv)
            last_fetch_addr_d = active_pc;
        if (state_q == ST_FETCH && DataReq) begin
            req_addr_d  = DataAddr;
            req_write_d = DataWrite;
            req_wdata_d = DataWData;
        end
        if (state_q == ST_DATA && !DataWait && !req_write_q)
            data_rdata_d = MemRData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcra0_q           <= '0;
            pcra1_q           <= '0;
            flip_q            <= 1'b0;
            last_fetch_addr_q <= '0;
            req_addr_q        <= '0;
            req_write_q       <= 1'b0;
            req_wdata_q       <= '0;
            data_rdata_q      <= '0;
        end else begin
            pcra0_q           <= pcra0_d;
            pcra1_q           <= pcra1_d;
            flip_q            <= flip_d;
            last_fetch_addr_q <= last_fetch_addr_d;
            req_addr_q        <= req_addr_d;
            req_write_q       <= req_write_d;
            req_wdata_q       <= req_wdata_d;
            data_rdata_q      <= data_rdata_d;
        end
    end

    // Output logic; reset forces a bubble with no bus strobes
    always_comb begin
        MemAddr       = active_pc;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemWData      = req_wdata_q;
        DataAck       = 1'b0;
        BusRequest    = 1'b1;
        FetchSuppress = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    if (DataReq || StallIn) begin
                        MemAddr       = last_fetch_addr_q;
                        FetchSuppress = 1'b1;
                    end else begin
                        BusRequest = 1'b0;
                    end
                end
                ST_DATA: begin
                    MemAddr  = req_addr_q;
                    MemRead  = !req_write_q;
                    MemWrite = req_write_q;
                    DataAck  = !DataWait;
                end
                default: ;
            endcase
        end
    end

    assign DataRData       = data_rdata_q;
    assign Flag5_PCRA_Flip = flip_q;
    assign PC              = active_pc;
endmodule

// File: tb/tb_fetch_bus_ctrl.sv
// Cycle-by-cycle bench for fetch_bus_ctrl: expected bus cycles are queued as stimulus is
// driven and compared against the DUT outputs on the falling edge.
module tb_fetch_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        BranchLoad;
    logic [15:0] BranchAddr;
    logic        PCFlipReq;
    logic        StallIn;
    logic        DataReq;
    logic        DataWrite;
    logic [15:0] DataAddr;
    logic [7:0]  DataWData;
    logic        DataWait;
    logic [7:0]  MemRData;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  MemWData;
    logic        DataAck;
    logic [7:0]  DataRData;
    logic        BusRequest;
    logic        FetchSuppress;
    logic        Flag5_PCRA_Flip;
    logic [15:0] PC;

    fetch_bus_ctrl #(.AW(16), .DW(8)) dut (
        .clk(clk), .rst(rst), .BranchLoad(BranchLoad), .BranchAddr(BranchAddr),
        .PCFlipReq(PCFlipReq), .StallIn(StallIn), .DataReq(DataReq), .DataWrite(DataWrite),
        .DataAddr(DataAddr), .DataWData(DataWData), .DataWait(DataWait), .MemRData(MemRData),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite), .MemWData(MemWData),
        .DataAck(DataAck), .DataRData(DataRData), .BusRequest(BusRequest),
        .FetchSuppress(FetchSuppress), .Flag5_PCRA_Flip(Flag5_PCRA_Flip), .PC(PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic        br;
        logic        fs;
        logic        ack;
        logic [15:0] pc;
        logic        flip;
        logic        chk_addr;
        logic        chk_wdata;
        logic [7:0]  wdata;
        logic        chk_rdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic rd, input logic wr,
                                input logic br, input logic fs, input logic ack,
                                input logic [15:0] pc, input logic fl);
        exp_t e;
        e.addr = a; e.rd = rd; e.wr = wr; e.br = br; e.fs = fs; e.ack = ack;
        e.pc = pc; e.flip = fl; e.chk_addr = 1'b1;
        e.chk_wdata = 1'b0; e.wdata = '0; e.chk_rdata = 1'b0; e.rdata = '0;
        return e;
    endfunction

    task automatic clr();
        BranchLoad = 0; BranchAddr = '0; PCFlipReq = 0; StallIn = 0; DataReq = 0;
        DataWrite = 0; DataAddr = '0; DataWData = '0; DataWait = 0; MemRData = '0;
    endtask

    // Inputs are already driven; queue the expectation and compare mid-cycle
    task automatic step(input string tag, input exp_t e);
        exp_t g;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        n_txn++;
        $display("txn %0d %s: addr=%h rd=%b wr=%b br/fs=%b%b ack=%b pc=%h flip=%b rdata=%h",
                 n_txn, tag, MemAddr, MemRead, MemWrite, BusRequest, FetchSuppress,
                 DataAck, PC, Flag5_PCRA_Flip, DataRData);
        if (g.chk_addr) check({tag, ".addr"}, 32'(MemAddr), 32'(g.addr));
        check({tag, ".rd"},   32'(MemRead),         32'(g.rd));
        check({tag, ".wr"},   32'(MemWrite),        32'(g.wr));
        check({tag, ".br"},   32'(BusRequest),      32'(g.br));
        check({tag, ".fs"},   32'(FetchSuppress),   32'(g.fs));
        check({tag, ".ack"},  32'(DataAck),         32'(g.ack));
        check({tag, ".pc"},   32'(PC),              32'(g.pc));
        check({tag, ".flip"}, 32'(Flag5_PCRA_Flip), 32'(g.flip));
        if (g.chk_wdata) check({tag, ".wdata"}, 32'(MemWData), 32'(g.wdata));
        if (g.chk_rdata) check({tag, ".rdata"}, 32'(DataRData), 32'(g.rdata));
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        exp_t e;
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        e = mk(16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0);
        e.chk_addr = 0; e.chk_rdata = 1; e.rdata = 8'h00;
        step("reset", e);
        rst = 0;

        // Free-running fetch from zero
        for (int i = 0; i < 4; i++)
            step("fetch0", mk(16'(i), 1, 0, 0, 0, 0, 16'(i), 0));

        // Branch to FFFE, then wrap through 0000
        BranchLoad = 1; BranchAddr = 16'hFFFE;
        step("br_fffe", mk(16'h0004, 1, 0, 0, 0, 0, 16'h0004, 0));
        step("wrap0", mk(16'hFFFE, 1, 0, 0, 0, 0, 16'hFFFE, 0));
        step("wrap1", mk(16'hFFFF, 1, 0, 0, 0, 0, 16'hFFFF, 0));
        step("wrap2", mk(16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0));

        // Data write at PC=0010
        BranchLoad = 1; BranchAddr = 16'h0010;
        step("br_0010", mk(16'h0001, 1, 0, 0, 0, 0, 16'h0001, 0));
        DataReq = 1; DataWrite = 1; DataAddr = 16'h8000; DataWData = 8'h5A;
        step("wr_req", mk(16'h0001, 1, 0, 1, 1, 0, 16'h0010, 0));
        e = mk(16'h8000, 0, 1, 1, 0, 1, 16'h0010, 0);
        e.chk_wdata = 1; e.wdata = 8'h5A;
        DataReq = 1; DataWrite = 0; DataAddr = 16'h9999;
        step("wr_data", e);
        step("wr_resume", mk(16'h0010, 1, 0, 0, 0, 0, 16'h0010, 0));

        // Data read with two wait cycles; DataReq outranks StallIn
        DataReq = 1; StallIn = 1; DataAddr = 16'h4321;
        step("rd_req", mk(16'h0010, 1, 0, 1, 1, 0, 16'h0011, 0));
        for (int i = 0; i < 2; i++) begin
            DataWait = 1; MemRData = 8'h11;
            e = mk(16'h4321, 1, 0, 1, 0, 0, 16'h0011, 0);
            e.chk_rdata = 1; e.rdata = 8'h00;
            step("rd_wait", e);
        end
        MemRData = 8'hC3;
        step("rd_ack", mk(16'h4321, 1, 0, 1, 0, 1, 16'h0011, 0));
        e = mk(16'h0011, 1, 0, 0, 0, 0, 16'h0011, 0);
        e.chk_rdata = 1; e.rdata = 8'hC3;
        step("rd_resume", e);

        for (int a = 16'h12; a <= 16'h1F; a++)
            step("fetch1", mk(16'(a), 1, 0, 0, 0, 0, 16'(a), 0));

        // Stall replays the last fetched address
        for (int i = 0; i < 2; i++) begin
            StallIn = 1;
            step("stall", mk(16'h001F, 1, 0, 1, 1, 0, 16'h0020, 0));
        end
        step("unstall", mk(16'h0020, 1, 0, 0, 0, 0, 16'h0020, 0));

        // Branch and flip on the same edge: branch hits PCRA0, PCRA1 stays untouched
        BranchLoad = 1; BranchAddr = 16'h1200; PCFlipReq = 1;
        step("br_flip", mk(16'h0021, 1, 0, 0, 0, 0, 16'h0021, 0));
        step("pcra1_0", mk(16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1));
        PCFlipReq = 1;
        step("pcra1_1", mk(16'h0001, 1, 0, 0, 0, 0, 16'h0001, 1));
        step("pcra0", mk(16'h1200, 1, 0, 0, 0, 0, 16'h1200, 0));

        // Reset in the middle of a waiting write abandons it
        DataReq = 1; DataWrite = 1; DataAddr = 16'h7777; DataWData = 8'hA5;
        step("wr2_req", mk(16'h1200, 1, 0, 1, 1, 0, 16'h1201, 0));
        DataWait = 1;
        e = mk(16'h7777, 0, 1, 1, 0, 0, 16'h1201, 0);
        e.chk_wdata = 1; e.wdata = 8'hA5;
        step("wr2_wait", e);
        rst = 1; DataWait = 1;
        e = mk(16'h0000, 0, 0, 1, 0, 0, 16'h1201, 0);
        e.chk_addr = 0;
        step("rst_data", e);
        rst = 0;
        step("post_rst0", mk(16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0));
        step("post_rst1", mk(16'h0001, 1, 0, 0, 0, 0, 16'h0001, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
